// File: rtl/fmul16_norm_round_if.sv
// Handshake and operand/result bundle for the F16 multiplier back end.
// The slave modport is the back end's own view of the bundle; the master modport is the producer/consumer side.
interface fmul16_norm_round_if #(
  parameter int TAG_W = 4
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic              sign_i;
  logic signed [6:0] exp_i;
  logic [21:0]       sig_mul_i;
  logic [2:0]        rm_i;
  logic [TAG_W-1:0]  tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [15:0]       res_o;
  logic [4:0]        fflags_o;
  logic [TAG_W-1:0]  tag_o;

  modport slave (
    input  in_valid_i, sign_i, exp_i, sig_mul_i, rm_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, fflags_o, tag_o
  );

  modport master (
    output in_valid_i, sign_i, exp_i, sig_mul_i, rm_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, fflags_o, tag_o
  );
endinterface

// File: rtl/fmul16_norm_round.sv
// F16 multiplier back end: normalize/denormalize the raw significand product, round, pack, raise fflags.
// Define FMUL16_FTZ_EN to flush subnormal results to signed zero instead of gradual underflow.
module fmul16_norm_round #(
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fmul16_norm_round_if.slave   bus
);

  function automatic logic [4:0] lzc22(input logic [21:0] v);
    lzc22 = 5'd22;
    for (int i = 0; i < 22; i++)
      if (v[i]) lzc22 = 5'(21 - i);
  endfunction

  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic l, input logic g, input logic s);
    case (rm)
      3'd1:    round_inc = 1'b0;
      3'd2:    round_inc = sign & (g | s);
      3'd3:    round_inc = ~sign & (g | s);
      3'd4:    round_inc = g;
      default: round_inc = g & (l | s);
    endcase
  endfunction

  function automatic logic [15:0] sat_result(input logic [2:0] rm, input logic sign);
    logic to_inf;
    case (rm)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = sign;
      3'd3:    to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase
    sat_result = to_inf ? {sign, 5'h1f, 10'h000} : {sign, 5'h1e, 10'h3ff};
  endfunction

  logic              r_vld_p1, r_vld_p2;
  logic              r_sign_p1, r_sticky_p1;
  logic [2:0]        r_rm_p1;
  logic [TAG_W-1:0]  r_tag_p1, r_tag_p2;
  logic [7:0]        r_exp_p1;
  logic [20:0]       r_sig_p1;
  logic [15:0]       r_res_p2;
  logic [4:0]        r_flags_p2;

  logic              w_adv_p1, w_in_ready;
  logic [4:0]        w_lzc;
  logic signed [7:0] w_exp_x, w_lzc_x, w_nexp;
  logic [3:0]        w_rsh;
  logic [21:0]       w_mask;
  logic [20:0]       w_sig_n;
  logic              w_sticky_n;
  logic [7:0]        w_exp_n;

  assign w_adv_p1        = ~r_vld_p2 | bus.out_ready_i;
  assign w_in_ready      = ~r_vld_p1 | w_adv_p1;
  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_vld_p2;
  assign bus.res_o       = r_res_p2;
  assign bus.fflags_o    = r_flags_p2;
  assign bus.tag_o       = r_tag_p2;

  // Stage p1: normalize left to put the leading one at bit 21, or align to the subnormal grid
  always_comb begin
    w_lzc      = lzc22(bus.sig_mul_i);
    w_exp_x    = {bus.exp_i[6], bus.exp_i};
    w_lzc_x    = $signed({3'b000, w_lzc});
    w_nexp     = -w_exp_x;
    w_rsh      = (w_nexp > 8'sd13) ? 4'd13 : w_nexp[3:0];
    w_mask     = (22'd1 << w_rsh) - 22'd1;
    w_sig_n    = '0;
    w_sticky_n = 1'b0;
    w_exp_n    = '0;
    if (bus.sig_mul_i != '0) begin
      if (w_exp_x >= w_lzc_x) begin
        w_sig_n = 21'(bus.sig_mul_i << w_lzc);
        w_exp_n = $unsigned(w_exp_x + 8'sd1 - w_lzc_x);
      end else if (!w_exp_x[7]) begin
        w_sig_n = 21'(bus.sig_mul_i << w_exp_x[4:0]);
      end else begin
        w_sig_n    = 21'(bus.sig_mul_i >> w_rsh);
        w_sticky_n = |(bus.sig_mul_i & w_mask);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_vld_p1 <= 1'b0;
    else if (w_in_ready) r_vld_p1 <= bus.in_valid_i;
  end

  always_ff @(posedge clk) begin
    if (w_in_ready && bus.in_valid_i) begin
      r_sign_p1   <= bus.sign_i;
      r_rm_p1     <= bus.rm_i;
      r_tag_p1    <= bus.tag_i;
      r_exp_p1    <= w_exp_n;
      r_sig_p1    <= w_sig_n;
      r_sticky_p1 <= w_sticky_n;
    end
  end

  // Stage p2: round; the exponent/mantissa add lets a carry bump the exponent (subnormal carry lands on 1)
  logic        w_l, w_g, w_s, w_inc, w_inc_lo, w_nx, w_tiny;
  logic [17:0] w_sum;
  logic [7:0]  w_exp_r;
  logic [9:0]  w_man_r;
  logic [15:0] w_res;
  logic [4:0]  w_flags;

  always_comb begin
    w_l      = r_sig_p1[11];
    w_g      = r_sig_p1[10];
    w_s      = (|r_sig_p1[9:0]) | r_sticky_p1;
    w_inc    = round_inc(r_rm_p1, r_sign_p1, w_l, w_g, w_s);
    w_sum    = {r_exp_p1, r_sig_p1[20:11]} + 18'(w_inc);
    w_exp_r  = w_sum[17:10];
    w_man_r  = w_sum[9:0];
    w_nx     = w_g | w_s;
    w_inc_lo = round_inc(r_rm_p1, r_sign_p1, r_sig_p1[10], r_sig_p1[9],
                         (|r_sig_p1[8:0]) | r_sticky_p1);
    w_tiny   = (r_exp_p1 == 8'd0) & ~((&r_sig_p1[20:10]) & w_inc_lo);
    w_res    = {r_sign_p1, w_exp_r[4:0], w_man_r};
    w_flags  = {3'b000, w_tiny & w_nx, w_nx};
    if (w_exp_r >= 8'd31) begin
      w_res   = sat_result(r_rm_p1, r_sign_p1);
      w_flags = 5'b00101;
    end
`ifdef FMUL16_FTZ_EN
    else if (w_exp_r == 8'd0 && w_man_r != 10'd0) begin
      w_res   = {r_sign_p1, 15'd0};
      w_flags = 5'b00011;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2   <= 1'b0;
      r_res_p2   <= '0;
      r_flags_p2 <= '0;
      r_tag_p2   <= '0;
    end else if (w_adv_p1) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_res_p2   <= w_res;
        r_flags_p2 <= w_flags;
        r_tag_p2   <= r_tag_p1;
      end
    end
  end

endmodule
